// File: rtl/slave_port_v3.sv
// slave_port_v3 -- serial bus slave with burst access to a local memory.
//
// A transaction starts when master_valid is seen in IDLE; mode is latched at
// that point (1 = write, 0 = read). The master then shifts ADDR_WIDTH address
// bits followed by BURST_WIDTH length bits, MSB first, on wr_bus. A write
// continues with LEN+1 words of DATA_WIDTH bits each. A read spends one cycle
// loading the first word and then streams LEN+1 words back on rd_bus.
// Addresses outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH) raise slave_err for the
// rest of the transaction: writes are dropped and reads return zeros.
//
// Handshake: the slave samples wr_bus on every rising edge where slave_ready
// and master_valid are both high. A low master_valid while slave_ready is high
// aborts the transaction. rd_bus advances on every rising edge where
// slave_valid and master_ready are both high. A low master_ready stalls the
// stream for as long as it stays low.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   mode           transaction direction, sampled on IDLE->ADDR
//   wr_bus         serial address/length/write data from the master
//   master_valid   wr_bus carries a valid bit
//   master_ready   master accepts the current rd_bus bit
//   rd_bus         serial read data, MSB first
//   slave_ready    slave samples wr_bus this cycle (ADDR, LEN, WDATA)
//   slave_valid    rd_bus holds a valid bit (SEND)
//   slave_err      current transaction misses the address window
module slave_port_v3 #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int BURST_WIDTH = 4,
  parameter int MEM_DEPTH   = 64,
  parameter int BASE_ADDR   = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic mode,
  input  logic wr_bus,
  input  logic master_valid,
  input  logic master_ready,
  output logic rd_bus,
  output logic slave_ready,
  output logic slave_valid,
  output logic slave_err
);

  localparam int IW   = $clog2(MEM_DEPTH);
  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH)
                      ? ((ADDR_WIDTH > BURST_WIDTH) ? ADDR_WIDTH : BURST_WIDTH)
                      : ((DATA_WIDTH > BURST_WIDTH) ? DATA_WIDTH : BURST_WIDTH);
  localparam int CW   = $clog2(MAXW + 1);

  typedef enum logic [2:0] {IDLE, ADDR, LEN, WDATA, READ, SEND} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          bit_cnt;
  logic [BURST_WIDTH:0]   beat_cnt;
  logic                   mode_q;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [BURST_WIDTH-1:0] len;
  logic [DATA_WIDTH-1:0]  shreg;
  logic [IW-1:0]          idx;
  logic                   hit;
  logic                   err;

  logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

  logic                   addr_last, len_last, data_last, beat_last;
  logic [BURST_WIDTH-1:0] len_full;
  logic [DATA_WIDTH-1:0]  wdata_full;
  logic [IW-1:0]          idx_inc, idx_c;
  logic                   hit_c;

  // Window decode is done one bit wider than the address so that a window
  // ending exactly at the top of the address space still compares correctly.
  always_comb begin
    addr_last  = (bit_cnt == CW'(ADDR_WIDTH - 1));
    len_last   = (bit_cnt == CW'(BURST_WIDTH - 1));
    data_last  = (bit_cnt == CW'(DATA_WIDTH - 1));
    beat_last  = (beat_cnt == {1'b0, len});
    len_full   = {len[BURST_WIDTH-2:0], wr_bus};
    wdata_full = {shreg[DATA_WIDTH-2:0], wr_bus};
    idx_inc    = idx + 1'b1;
    hit_c      = ({1'b0, addr} >= (ADDR_WIDTH+1)'(BASE_ADDR)) &&
                 ({1'b0, addr} <  (ADDR_WIDTH+1)'(BASE_ADDR + MEM_DEPTH));
    idx_c      = IW'(addr - ADDR_WIDTH'(BASE_ADDR));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    slave_ready = 1'b0;
    slave_valid = 1'b0;
    rd_bus      = 1'b0;
    slave_err   = err;
    case (state)
      IDLE:  if (master_valid) state_nxt = ADDR;
      ADDR: begin
        slave_ready = 1'b1;
        if (!master_valid)  state_nxt = IDLE;
        else if (addr_last) state_nxt = LEN;
      end
      LEN: begin
        slave_ready = 1'b1;
        if (!master_valid)  state_nxt = IDLE;
        else if (len_last)  state_nxt = mode_q ? WDATA : READ;
      end
      WDATA: begin
        slave_ready = 1'b1;
        if (!master_valid)               state_nxt = IDLE;
        else if (data_last && beat_last) state_nxt = IDLE;
      end
      READ:  state_nxt = SEND;
      SEND: begin
        slave_valid = 1'b1;
        rd_bus      = shreg[DATA_WIDTH-1];
        if (master_ready && data_last && beat_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      beat_cnt <= '0;
      mode_q   <= 1'b0;
      addr     <= '0;
      len      <= '0;
      shreg    <= '0;
      idx      <= '0;
      hit      <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt  <= '0;
          beat_cnt <= '0;
          if (master_valid) mode_q <= mode;
        end
        ADDR: if (master_valid) begin
          addr    <= {addr[ADDR_WIDTH-2:0], wr_bus};
          bit_cnt <= addr_last ? '0 : bit_cnt + 1'b1;
        end
        LEN: if (master_valid) begin
          len <= len_full;
          if (len_last) begin
            bit_cnt <= '0;
            hit     <= hit_c;
            err     <= !hit_c;
            idx     <= idx_c;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        WDATA: if (master_valid) begin
          shreg <= wdata_full;
          if (data_last) begin
            bit_cnt  <= '0;
            beat_cnt <= beat_cnt + 1'b1;
            idx      <= idx_inc;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        READ: shreg <= hit ? mem[idx] : '0;
        SEND: if (master_ready) begin
          if (data_last) begin
            // Reload the next word on the same edge so beats run back to back.
            bit_cnt  <= '0;
            beat_cnt <= beat_cnt + 1'b1;
            idx      <= idx_inc;
            shreg    <= hit ? mem[idx_inc] : '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            shreg   <= shreg << 1;
          end
        end
        default: ;
      endcase
      // The error flag lives only as long as the transaction.
      if (state_nxt == IDLE) err <= 1'b0;
    end
  end

  // Memory has no reset; only complete, in-window beats are stored.
  always_ff @(posedge clk) begin
    if (!rst && state == WDATA && master_valid && data_last && hit)
      mem[idx] <= wdata_full;
  end

endmodule

// File: tb/tb_slave_port_v3.sv
module tb_slave_port_v3;

  logic clk = 1'b0;
  logic rst, mode, wr_bus, master_valid, master_ready;
  logic rd0, ready0, valid0, err0;
  logic rd1, ready1, valid1, err1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference memories: value plus a "known" flag (unwritten words read X).
  logic [7:0] m0 [64];
  logic [7:0] m1 [64];
  bit         k0 [64];
  bit         k1 [64];
  logic [7:0] wdat [16];

  localparam int BASE1 = 32'h100;

  always #5 clk = ~clk;

  // Two instances see the same stimulus: one decodes 0x0000.., one 0x0100..
  slave_port_v3 dut (
    .clk(clk), .rst(rst), .mode(mode), .wr_bus(wr_bus),
    .master_valid(master_valid), .master_ready(master_ready),
    .rd_bus(rd0), .slave_ready(ready0), .slave_valid(valid0), .slave_err(err0)
  );

  slave_port_v3 #(.BASE_ADDR(BASE1)) dut_ob (
    .clk(clk), .rst(rst), .mode(mode), .wr_bus(wr_bus),
    .master_valid(master_valid), .master_ready(master_ready),
    .rd_bus(rd1), .slave_ready(ready1), .slave_valid(valid1), .slave_err(err1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_win(int base, int a);
    return (a >= base) && (a < base + 64);
  endfunction

  task automatic model_write(input int a, input int b, input logic [7:0] d);
    if (in_win(0, a))     begin m0[(a + b) & 63] = d;         k0[(a + b) & 63] = 1; end
    if (in_win(BASE1, a)) begin m1[(a - BASE1 + b) & 63] = d; k1[(a - BASE1 + b) & 63] = 1; end
  endtask

  task automatic send_header(input int a, input int len);
    for (int i = 15; i >= 0; i--) begin wr_bus = a[i]; step(); end
    for (int i = 3; i >= 0; i--)  begin wr_bus = len[i]; step(); end
  endtask

  // Write burst using wdat[0..len]; abort_beat >= 0 drops master_valid
  // after abort_bit bits of that beat.
  task automatic do_write(input int a, input int len, input int abort_beat, input int abort_bit);
    int rdy_cnt = 0;
    int err_bad = 0;
    bit ab = 0;
    bit h0 = in_win(0, a);
    bit h1 = in_win(BASE1, a);
    mode = 1; master_valid = 1; wr_bus = 1'($urandom_range(0, 1));
    step();
    for (int i = 15; i >= 0; i--) begin wr_bus = a[i]; rdy_cnt += int'(ready0); step(); end
    for (int i = 3; i >= 0; i--)  begin wr_bus = len[i]; rdy_cnt += int'(ready0); step(); end
    check("wr_err_dut0", err0, !h0);
    check("wr_err_dut1", err1, !h1);
    for (int b = 0; b <= len; b++) begin
      for (int p = 0; p < 8; p++) begin
        if (b == abort_beat && p == abort_bit) begin ab = 1; break; end
        wr_bus = wdat[b][7-p];
        rdy_cnt += int'(ready0);
        if (err0 !== !h0 || err1 !== !h1) err_bad++;
        step();
      end
      if (ab) break;
      model_write(a, b, wdat[b]);
    end
    master_valid = 0; wr_bus = 0;
    if (ab) begin
      rdy_cnt += int'(ready0);
      step();
      check("wr_ready_cycles", rdy_cnt, 20 + abort_beat * 8 + abort_bit + 1);
    end else begin
      check("wr_ready_cycles", rdy_cnt, 20 + (len + 1) * 8);
    end
    check("wr_idle_ready", ready0, 0);
    check("wr_idle_err", {err0, err1}, 0);
    check("wr_err_hold", err_bad, 0);
  endtask

  // Read burst; stall_at/stall_len force a stall at a bit position, rnd
  // randomises master_ready, rst_at >= 0 resets at that accepted bit.
  task automatic do_read(input int a, input int len, input int stall_at, input int stall_len,
                         input bit rnd, input int rst_at);
    int acc = 0, cyc = 0, stalls = 0, forced = 0;
    int hold_bad = 0, valid_bad = 0, last_acc = -1;
    int total = (len + 1) * 8;
    logic last_rd = 0;
    logic [7:0] w0 = 0, w1 = 0;
    bit r;
    int b, i0, i1;
    bit h0 = in_win(0, a);
    bit h1 = in_win(BASE1, a);
    mode = 0; master_valid = 1; wr_bus = 1'($urandom_range(0, 1));
    step();
    send_header(a, len);
    master_valid = 0; wr_bus = 0;
    check("rd_read_valid", valid0, 0);
    check("rd_err_dut0", err0, !h0);
    check("rd_err_dut1", err1, !h1);
    step();
    while (acc < total && cyc < 2000) begin
      if (rst_at == acc) begin
        rst = 1;
        step();
        rst = 0;
        check("rst_outputs_dut0", {rd0, ready0, valid0, err0}, 0);
        check("rst_outputs_dut1", {rd1, ready1, valid1, err1}, 0);
        return;
      end
      if (valid0 !== 1'b1 || valid1 !== 1'b1 || err0 !== !h0 || err1 !== !h1) valid_bad++;
      if (acc == last_acc && (rd0 !== last_rd)) hold_bad++;
      last_acc = acc; last_rd = rd0;
      if (stall_at == acc && forced < stall_len) begin r = 0; forced++; end
      else r = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      master_ready = r;
      if (r) begin
        w0 = {w0[6:0], rd0};
        w1 = {w1[6:0], rd1};
        acc++;
        if (acc % 8 == 0) begin
          b  = acc / 8 - 1;
          i0 = (a + b) & 63;
          i1 = (a - BASE1 + b) & 63;
          if (!h0)        check("rd_word_dut0", w0, 0);
          else if (k0[i0]) check("rd_word_dut0", w0, m0[i0]);
          if (!h1)        check("rd_word_dut1", w1, 0);
          else if (k1[i1]) check("rd_word_dut1", w1, m1[i1]);
        end
      end else begin
        stalls++;
      end
      step();
      cyc++;
    end
    master_ready = 0;
    check("rd_send_cycles", cyc, total + stalls);
    check("rd_valid_after", {valid0, valid1, err0, err1}, 0);
    check("rd_hold", hold_bad, 0);
    check("rd_valid_during", valid_bad, 0);
  endtask

  initial begin
    int a, len;
    rst = 1; mode = 0; wr_bus = 0; master_valid = 0; master_ready = 0;
    for (int i = 0; i < 64; i++) begin k0[i] = 0; k1[i] = 0; end
    repeat (3) step();
    check("reset_dut0", {rd0, ready0, valid0, err0}, 0);
    check("reset_dut1", {rd1, ready1, valid1, err1}, 0);
    rst = 0;
    step();
    check("idle_ready", ready0, 0);

    // Single write/read.
    wdat[0] = 8'hA5;
    do_write(16'h0005, 0, -1, 0);
    do_read(16'h0005, 0, -1, 0, 0, -1);

    // Wrapping burst, then read the wrapped words from word 0.
    wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33; wdat[3] = 8'h44;
    do_write(16'h003E, 3, -1, 0);
    do_read(16'h003E, 3, -1, 0, 0, -1);
    do_read(16'h0000, 1, -1, 0, 0, -1);

    // Out of window: a miss must not disturb the words a false hit would hit.
    wdat[0] = 8'h66; do_write(16'h0010, 0, -1, 0);
    wdat[0] = 8'h77; do_write(16'h0110, 0, -1, 0);
    wdat[0] = 8'h5A; do_write(16'h0050, 0, -1, 0);
    do_read(16'h0050, 0, -1, 0, 0, -1);
    do_read(16'h0010, 0, -1, 0, 0, -1);
    do_read(16'h0110, 0, -1, 0, 0, -1);

    // Stall five cycles mid-word during a two-beat read.
    wdat[0] = 8'hC3; wdat[1] = 8'h3C;
    do_write(16'h0020, 1, -1, 0);
    do_read(16'h0020, 1, 3, 5, 0, -1);

    // Abort after two bits of beat 2: beats 0,1 land, beat 2 keeps old value.
    wdat[0] = 8'h01; wdat[1] = 8'h02; wdat[2] = 8'h03;
    do_write(16'h0018, 2, -1, 0);
    wdat[0] = 8'hAA; wdat[1] = 8'hBB; wdat[2] = 8'hCC;
    do_write(16'h0018, 2, 2, 2);
    do_read(16'h0018, 2, -1, 0, 0, -1);

    // Reset mid-SEND, then normal traffic.
    do_read(16'h0020, 1, -1, 0, 0, 5);
    wdat[0] = 8'h9E;
    do_write(16'h0021, 0, -1, 0);
    do_read(16'h0020, 1, -1, 0, 0, -1);

    // Random bursts across and around both windows with random back-pressure.
    for (int t = 0; t < 24; t++) begin
      a   = $urandom_range(0, 16'h017F);
      len = $urandom_range(0, 15);
      for (int i = 0; i < 16; i++) wdat[i] = 8'($urandom_range(0, 255));
      do_write(a, len, -1, 0);
      do_read(a, len, -1, 0, 1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
